// File: rtl/lsu_dmem_ctrl_if.sv
// Request bundle between MEM stage and LSU, and the LSU-to-dmem port.
// Master drives the request; slave answers it.
interface lsu_req_if;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] addr;
  logic [2:0]  funct3;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        stall;
  logic        acc_err;
  logic        err_sticky;

  modport master (
    output mem_read, mem_write, addr, funct3, wdata,
    input  rdata, stall, acc_err, err_sticky
  );
  modport slave (
    input  mem_read, mem_write, addr, funct3, wdata,
    output rdata, stall, acc_err, err_sticky
  );
endinterface

interface dmem_if #(
  parameter int AW = 10
);
  logic [AW-1:0] addr;
  logic [63:0]   din;
  logic [63:0]   dout;
  logic          read;
  logic          write;

  modport master (
    output addr, din, read, write,
    input  dout
  );
  modport slave (
    input  addr, din, read, write,
    output dout
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: byte-addressed B/H/W/D accesses onto 64-bit dmem entries.
// Sub-doubleword stores use a two-cycle read-modify-write.
module lsu_dmem_ctrl #(
  parameter int DMEM_ADDR_WIDTH = 10
) (
  input  logic   clk,
  input  logic   rst,
  lsu_req_if.slave req,
  dmem_if.master   dmem
);

  localparam int AW = DMEM_ADDR_WIDTH;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t        state, state_nxt;
  logic          err_q;
  logic [AW-1:0] lat_idx;
  logic [63:0]   lat_merged;

  logic [2:0]    off;
  logic [5:0]    sh;
  logic [1:0]    size;
  logic          uns;
  logic [AW-1:0] idx;
  logic          is_st, is_ld;
  logic          misal, err, acc_err;
  logic [63:0]   lane_mask, lane;
  logic [63:0]   merged, load_val;
  logic          unused_addr;

  assign off  = req.addr[2:0];
  assign sh   = {off, 3'b000};
  assign size = req.funct3[1:0];
  assign uns  = req.funct3[2];
  assign idx  = req.addr[AW+2:3];
  assign unused_addr = ^req.addr[63:AW+3];

  assign is_st = req.mem_write;
  assign is_ld = req.mem_read & ~req.mem_write;

  always_comb begin
    misal     = 1'b0;
    lane_mask = '1;
    unique case (size)
      2'd0: lane_mask = 64'h0000_0000_0000_00FF;
      2'd1: begin
        misal     = off[0];
        lane_mask = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        misal     = |off[1:0];
        lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: misal = |off;
    endcase
  end

  assign err = (is_st | is_ld) &
               (misal | (req.funct3 == 3'b111) | (is_st & uns));
  assign acc_err = err & (state == IDLE);

  // Target lanes of the live dmem word replaced by the store data.
  assign merged = (dmem.dout & ~(lane_mask << sh)) |
                  ((req.wdata << sh) & (lane_mask << sh));
  assign lane = dmem.dout >> sh;

  always_comb begin
    load_val = lane;
    unique case (1'b1)
      size == 2'd0:
        load_val = uns ? {56'b0, lane[7:0]}
                       : {{56{lane[7]}}, lane[7:0]};
      size == 2'd1:
        load_val = uns ? {48'b0, lane[15:0]}
                       : {{48{lane[15]}}, lane[15:0]};
      size == 2'd2:
        load_val = uns ? {32'b0, lane[31:0]}
                       : {{32{lane[31]}}, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    dmem.addr  = idx;
    dmem.din   = '0;
    dmem.read  = 1'b0;
    dmem.write = 1'b0;
    req.stall  = 1'b0;
    req.rdata  = '0;
    unique case (state)
      IDLE: begin
        if (!rst && !err) begin
          if (is_st && size == 2'd3) begin
            dmem.write = 1'b1;
            dmem.din   = req.wdata;
          end else if (is_st) begin
            dmem.read = 1'b1;
            req.stall = 1'b1;
            state_nxt = RMW_WR;
          end else if (is_ld) begin
            dmem.read = 1'b1;
            req.rdata = load_val;
          end
        end
      end
      default: begin
        // A reset here drops the pending store.
        dmem.addr  = lat_idx;
        dmem.din   = lat_merged;
        dmem.write = ~rst;
        state_nxt  = IDLE;
      end
    endcase
  end

  assign req.acc_err    = acc_err;
  assign req.err_sticky = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      err_q      <= 1'b0;
      lat_idx    <= '0;
      lat_merged <= '0;
    end else begin
      state <= state_nxt;
      if (acc_err)
        err_q <= 1'b1;
      if (state == IDLE && state_nxt == RMW_WR) begin
        lat_idx    <= idx;
        lat_merged <= merged;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Randomized bench for lsu_dmem_ctrl against a byte-array model.
// Directed cases first, then a random mix of loads/stores.
module tb_lsu_dmem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_req_if      rq ();
  dmem_if #(.AW(10)) dm ();

  lsu_dmem_ctrl #(.DMEM_ADDR_WIDTH(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (rq),
    .dmem (dm)
  );

  logic [63:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [63:0] pl_val = '0;

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_idx] <= pl_val;
    else if (dm.write)
      mem[dm.addr] <= dm.din;
  end
  assign dm.dout = dm.read ? mem[dm.addr] : 64'h0;

  logic [7:0] rb [0:8191];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] a,
                                           input logic [2:0] f3);
    int n;
    int base;
    logic [63:0] v;
    n    = 1 << f3[1:0];
    base = int'(a[12:0]);
    v    = '0;
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = rb[base + k];
    if (!f3[2] && n < 8 && v[8*n-1])
      v = v | ({64{1'b1}} << (8*n));
    return v;
  endfunction

  task automatic set_entry(input int e, input logic [63:0] v);
    for (int k = 0; k < 8; k++)
      rb[e*8 + k] = v[8*k +: 8];
  endtask

  task automatic do_op(input logic rd, input logic wr,
                       input logic [63:0] a, input logic [2:0] f3,
                       input logic [63:0] wd, output logic [63:0] got);
    int n, off, e;
    logic st, ld, mis, err;
    logic [63:0] m;
    n   = 1 << f3[1:0];
    off = int'(a[2:0]);
    e   = int'(a[12:3]);
    st  = wr;
    ld  = rd & ~wr;
    mis = (off % n) != 0;
    err = (st || ld) && (mis || f3 == 3'b111 || (st && f3[2]));
    rq.mem_read  = rd;
    rq.mem_write = wr;
    rq.addr      = a;
    rq.funct3    = f3;
    rq.wdata     = wd;
    #3;
    got = rq.rdata;
    chk("acc_err", 64'(rq.acc_err), 64'(err));
    if (err) begin
      chk("err_quiet", {61'b0, dm.read, dm.write, rq.stall}, 64'h0);
      chk("err_rdata", rq.rdata, 64'h0);
      @(posedge clk); #1;
      chk("err_sticky", 64'(rq.err_sticky), 64'h1);
    end else if (ld) begin
      chk("ld_rdata", rq.rdata, ref_load(a, f3));
      chk("ld_stall", 64'(rq.stall), 64'h0);
      chk("ld_idx", 64'(dm.addr), 64'(e));
      @(posedge clk); #1;
    end else if (st && n == 8) begin
      chk("sd_io", {62'b0, rq.stall, dm.write}, 64'h1);
      chk("sd_din", dm.din, wd);
      @(posedge clk); #1;
      set_entry(e, wd);
    end else if (st) begin
      chk("st_stall", {62'b0, rq.stall, dm.read}, 64'h3);
      for (int k = 0; k < 8; k++)
        if (k >= off && k < off + n)
          m[8*k +: 8] = wd[8*(k-off) +: 8];
        else
          m[8*k +: 8] = rb[e*8 + k];
      @(posedge clk); #1;
      chk("rmw_io", {61'b0, rq.stall, dm.read, dm.write}, 64'h1);
      chk("rmw_din", dm.din, m);
      chk("rmw_idx", 64'(dm.addr), 64'(e));
      chk("rmw_err", 64'(rq.acc_err), 64'h0);
      @(posedge clk); #1;
      set_entry(e, m);
    end else begin
      chk("idle_io", {61'b0, rq.stall, dm.read, dm.write}, 64'h0);
      chk("idle_out", rq.rdata | dm.din, 64'h0);
      @(posedge clk); #1;
    end
  endtask

  logic [63:0] r;
  logic [63:0] ra;

  initial begin
    for (int i = 0; i < 8192; i++) rb[i] = 8'h0;
    rq.mem_read  = 1'b1;
    rq.mem_write = 1'b0;
    rq.addr      = 64'h10;
    rq.funct3    = 3'b011;
    rq.wdata     = '0;
    // Clear the entries the bench uses, then preload entry 2.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      pl_en  = 1'b1;
      pl_idx = (i < 8) ? 10'(i) : 10'd2;
      pl_val = (i < 8) ? 64'h0 : 64'h8877_6655_4433_2211;
      #3;
      chk("rst_out", {61'b0, rq.stall, dm.read, dm.write} | rq.rdata,
          64'h0);
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
    set_entry(2, 64'h8877_6655_4433_2211);
    #3;
    chk("rst_sticky", 64'(rq.err_sticky), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(1, 0, 64'h17, 3'b000, 0, r); chk("lb", r, 64'hFFFF_FFFF_FFFF_FF88);
    do_op(1, 0, 64'h17, 3'b100, 0, r); chk("lbu", r, 64'h88);
    do_op(1, 0, 64'h14, 3'b010, 0, r); chk("lw", r, 64'hFFFF_FFFF_8877_6655);
    do_op(1, 0, 64'h14, 3'b110, 0, r); chk("lwu", r, 64'h8877_6655);
    do_op(1, 0, 64'h10, 3'b011, 0, r); chk("ld", r, 64'h8877_6655_4433_2211);

    do_op(0, 1, 64'h12, 3'b001, 64'hBEEF, r);
    do_op(1, 0, 64'h10, 3'b011, 0, r); chk("sh_ld", r, 64'h8877_6655_BEEF_2211);

    do_op(0, 1, 64'h18, 3'b011, 64'h0123_4567_89AB_CDEF, r);
    do_op(1, 0, 64'h18, 3'b011, 0, r); chk("sd_ld", r, 64'h0123_4567_89AB_CDEF);
    do_op(0, 1, 64'h19, 3'b010, 64'h1, r);

    do_op(0, 1, 64'h10, 3'b000, 64'hAA, r);
    do_op(0, 1, 64'h11, 3'b000, 64'hBB, r);
    do_op(1, 0, 64'h10, 3'b011, 0, r); chk("sb2_ld", r, 64'h8877_6655_BEEF_BBAA);

    // Reset during the write half of an RMW must drop the store.
    rq.mem_read  = 1'b0;
    rq.mem_write = 1'b1;
    rq.addr      = 64'h10;
    rq.funct3    = 3'b000;
    rq.wdata     = 64'h55;
    #3;
    chk("rstrmw_stall", 64'(rq.stall), 64'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    chk("rstrmw_io", {61'b0, rq.stall, dm.read, dm.write}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rq.mem_write = 1'b0;
    #3;
    chk("rstrmw_sticky", 64'(rq.err_sticky), 64'h0);
    @(posedge clk); #1;
    do_op(1, 0, 64'h2010, 3'b011, 0, r);
    chk("wrap_ld", r, 64'h8877_6655_BEEF_BBAA);

    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      ra[12:3] = 10'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
      do_op(1'($urandom), 1'($urandom), ra, 3'($urandom),
            {$urandom, $urandom}, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
